// File: rtl/i2c_slave_read_byte.sv
// i2c_slave_read_byte: slave-side I2C receive engine for a single byte.
// Samples SDA on each SCL rising edge (MSB first) and hands every bit to the
// parent controller as a one-cycle load strobe, then pulses finish after the
// last bit. An SDA change while SCL is high (START/STOP inside the byte)
// abandons the byte with a one-cycle error pulse.
// Optional build macro: I2C_SLAVE_INPUT_SYNC_EN adds a two-flop synchronizer
// on scl and sda ahead of edge detection (bus-relative latency grows by 2).
module i2c_slave_read_byte #(
    parameter int BIT_COUNT = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic go,
    input  logic scl,
    input  logic sda,
    output logic data,
    output logic load,
    output logic finish,
    output logic error
);

    localparam int CW = $clog2(BIT_COUNT) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RECV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic sclIn;
    logic sdaIn;

`ifdef I2C_SLAVE_INPUT_SYNC_EN
    logic [1:0] sclSync_q;
    logic [1:0] sdaSync_q;

    // Two-flop synchronizer per bus line, parked at the bus-idle level
    always_ff @(posedge clock) begin
        if (reset) begin
            sclSync_q <= 2'b11;
            sdaSync_q <= 2'b11;
        end else begin
            sclSync_q <= {sclSync_q[0], scl};
            sdaSync_q <= {sdaSync_q[0], sda};
        end
    end

    assign sclIn = sclSync_q[1];
    assign sdaIn = sdaSync_q[1];
`else
    assign sclIn = scl;
    assign sdaIn = sda;
`endif

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          sclPrev_q;
    logic          sdaPrev_q;
    logic          data_q, data_d;
    logic          load_q, load_d;
    logic          finish_q, finish_d;
    logic          error_q, error_d;

    logic          rise;
    logic          hiChange;
    logic [CW-1:0] countInc;

    assign rise     = sclIn & ~sclPrev_q;
    assign hiChange = sclIn & sclPrev_q & (sdaIn != sdaPrev_q);
    assign countInc = count_q + 1'b1;

    // Previous-sample registers for edge detection, updated in every state
    always_ff @(posedge clock) begin
        if (reset) begin
            sclPrev_q <= 1'b1;
            sdaPrev_q <= 1'b1;
        end else begin
            sclPrev_q <= sclIn;
            sdaPrev_q <= sdaIn;
        end
    end

    // Next-state and registered-output decode; a high-phase SDA change beats a rise
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        data_d   = 1'b0;
        load_d   = 1'b0;
        finish_d = 1'b0;
        error_d  = 1'b0;
        case (state_q)
            IDLE: begin
                count_d = '0;
                if (go) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                if (!go) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (hiChange) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else if (rise) begin
                    data_d  = sdaIn;
                    load_d  = 1'b1;
                    count_d = countInc;
                    if (countInc == CW'(BIT_COUNT)) begin
                        finish_d = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            DONE: begin
                if (!go) begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // State, bit counter and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            data_q   <= 1'b0;
            load_q   <= 1'b0;
            finish_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            data_q   <= data_d;
            load_q   <= load_d;
            finish_q <= finish_d;
            error_q  <= error_d;
        end
    end

    assign data   = data_q;
    assign load   = load_q;
    assign finish = finish_q;
    assign error  = error_q;

endmodule

// File: tb/tb_i2c_slave_read_byte.sv
// tb_i2c_slave_read_byte: directed bench for the single-byte I2C receiver.
// Expected bits are queued as SCL pulses are driven and popped by a monitor
// whenever the receiver strobes load.
module tb_i2c_slave_read_byte;

    typedef struct packed {
        logic bitVal;
        logic isLast;
    } exp_t;

    logic clock;
    logic reset;
    logic go;
    logic scl;
    logic sda;
    logic data;
    logic load;
    logic finish;
    logic error;

    exp_t expQ[$];
    int   checks     = 0;
    int   errors     = 0;
    int   loadsSeen  = 0;
    int   finishSeen = 0;
    int   errSeen    = 0;
    int   loadsExp   = 0;
    int   finishExp  = 0;
    int   errExp     = 0;
    bit   monitorOn  = 1'b0;

    i2c_slave_read_byte #(.BIT_COUNT(8)) dut (
        .clock  (clock),
        .reset  (reset),
        .go     (go),
        .scl    (scl),
        .sda    (sda),
        .data   (data),
        .load   (load),
        .finish (finish),
        .error  (error)
    );

    // Free-running 10 ns clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One SCL pulse carrying bit b; SDA only moves while SCL is low
    task automatic applyStimulus(input logic b, input bit expectLoad, input bit expectLast);
        scl = 1'b0;
        sda = b;
        if (expectLoad) begin
            expQ.push_back({b, expectLast});
            loadsExp++;
            if (expectLast) finishExp++;
        end
        waitCycles(2);
        scl = 1'b1;
        waitCycles(3);
        scl = 1'b0;
        waitCycles(1);
    endtask

    task automatic sendBits(input logic [7:0] value, input int nBits, input bit finishOnLast);
        for (int i = 0; i < nBits; i++) begin
            applyStimulus(value[7-i], 1'b1, finishOnLast && (i == 7));
        end
    endtask

    task automatic checkCounts(input string tag);
        waitCycles(4);
        checkOutput({tag, ".loads"}, loadsSeen, loadsExp);
        checkOutput({tag, ".finish"}, finishSeen, finishExp);
        checkOutput({tag, ".error"}, errSeen, errExp);
        checkOutput({tag, ".pending"}, expQ.size(), 0);
    endtask

    // Monitor: pops the scoreboard on every load and polices quiet cycles
    always @(negedge clock) begin
        if (monitorOn) begin
            if (finish) finishSeen++;
            if (error) errSeen++;
            if (load === 1'b1) begin
                loadsSeen++;
                checkOutput("loadNoError", error, 1'b0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedLoad", load, 1'b0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("loadData", data, e.bitVal);
                    checkOutput("loadFinish", finish, e.isLast);
                end
            end else begin
                checkOutput("idleLoad", load, 1'b0);
                checkOutput("idleData", data, 1'b0);
                checkOutput("idleFinish", finish, 1'b0);
            end
        end
    end

    // Directed sequence
    initial begin
        logic [7:0] bytes [4];
        bytes[0] = 8'h13;
        bytes[1] = 8'h57;
        bytes[2] = 8'h9B;
        bytes[3] = 8'hDF;

        reset = 1'b1;
        go    = 1'b0;
        scl   = 1'b1;
        sda   = 1'b1;
        waitCycles(2);
        @(negedge clock);
        checkOutput("rst.load", load, 1'b0);
        checkOutput("rst.data", data, 1'b0);
        checkOutput("rst.finish", finish, 1'b0);
        checkOutput("rst.error", error, 1'b0);
        reset = 1'b0;
        monitorOn = 1'b1;
        waitCycles(2);
        scl = 1'b0;
        waitCycles(2);

        // Back-to-back bytes (the first is the single 0x13 case)
        for (int b = 0; b < 4; b++) begin
            go = 1'b1;
            waitCycles(1);
            sendBits(bytes[b], 8, 1'b1);
            checkCounts("byte");
            go = 1'b0;
            waitCycles(1);
        end

        // SDA toggled while SCL high after 3 bits of 0xA5
        go = 1'b1;
        waitCycles(1);
        sendBits(8'hA5, 3, 1'b0);
        scl = 1'b0;
        sda = 1'b1;
        waitCycles(2);
        scl = 1'b1;
        expQ.push_back({1'b1, 1'b0});
        loadsExp++;
        waitCycles(2);
        sda = 1'b0;
        errExp++;
        waitCycles(4);
        scl = 1'b0;
        waitCycles(2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkCounts("hiChange");
        go = 1'b0;
        waitCycles(1);

        // go dropped after 5 bits, then a full 0xC3
        go = 1'b1;
        waitCycles(1);
        sendBits(8'hA5, 5, 1'b0);
        waitCycles(2);
        go = 1'b0;
        waitCycles(1);
        go = 1'b1;
        waitCycles(1);
        sendBits(8'hC3, 8, 1'b1);
        checkCounts("goDrop");
        go = 1'b0;
        waitCycles(1);

        // Reset mid-byte, then a full 0x5A
        go = 1'b1;
        waitCycles(1);
        sendBits(8'h5A, 4, 1'b0);
        reset = 1'b1;
        waitCycles(1);
        @(negedge clock);
        checkOutput("midRst.load", load, 1'b0);
        checkOutput("midRst.finish", finish, 1'b0);
        checkOutput("midRst.error", error, 1'b0);
        reset = 1'b0;
        waitCycles(2);
        sendBits(8'h5A, 8, 1'b1);
        checkCounts("afterRst");
        go = 1'b0;
        waitCycles(1);

        // Extra SCL pulses after finish with go still high are ignored
        go = 1'b1;
        waitCycles(1);
        sendBits(8'h9B, 8, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkCounts("extraScl");
        go = 1'b0;
        waitCycles(1);
        go = 1'b1;
        waitCycles(1);
        sendBits(8'hDF, 8, 1'b1);
        checkCounts("rearm");
        go = 1'b0;
        waitCycles(2);

        monitorOn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
